// File: rtl/id_ex_stage.sv
// ID/EX pipeline register plus EX-stage operand selection and load-use hazard detection.
// Latency: one cycle from ID inputs to EX outputs; EX outputs are combinational from the register and M/W inputs.
// Backpressure: stall holds the register; load_hazard (combinational) tells ID/IF to hold while a bubble enters.
//
// Optional feature macro: IDEX_FWD_EN
//   defined   : EX/MEM and MEM/WB results are forwarded into the EX operands; only
//               load-use dependencies against the EX register raise load_hazard.
//   undefined : operands come straight from the register file read data; load_hazard
//               fires on any RAW dependency against the EX register or EX/MEM.
//
// Ports
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   stall, flush             hold the register / replace the incoming instruction with a bubble
//   d_*                      decoded instruction from ID (valid, operands, indices, control)
//   m_wreg, m_rn, m_alu      EX/MEM writeback info
//   w_wreg, w_rn, w_data     MEM/WB writeback info
//   load_hazard              ID/IF must hold this cycle
//   alu_a, alu_b, aluc       ALU operands and opcode
//   e_valid, e_wreg, e_m2reg, e_wmem, e_rn, e_store   EX-stage control passed down the pipe

module id_ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        d_valid,
    input  logic [31:0] d_qa,
    input  logic [31:0] d_qb,
    input  logic [31:0] d_imm,
    input  logic [4:0]  d_sa,
    input  logic [4:0]  d_rs,
    input  logic [4:0]  d_rt,
    input  logic [4:0]  d_rn,
    input  logic [3:0]  d_aluc,
    input  logic        d_aluimm,
    input  logic        d_shift,
    input  logic        d_wreg,
    input  logic        d_m2reg,
    input  logic        d_wmem,
    input  logic        m_wreg,
    input  logic [4:0]  m_rn,
    input  logic [31:0] m_alu,
    input  logic        w_wreg,
    input  logic [4:0]  w_rn,
    input  logic [31:0] w_data,
    output logic        load_hazard,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  aluc,
    output logic        e_valid,
    output logic        e_wreg,
    output logic        e_m2reg,
    output logic        e_wmem,
    output logic [4:0]  e_rn,
    output logic [31:0] e_store
);

    typedef struct packed {
        logic        valid;
        logic [31:0] qa;
        logic [31:0] qb;
        logic [31:0] imm;
        logic [4:0]  sa;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rn;
        logic [3:0]  aluc;
        logic        aluimm;
        logic        shift;
        logic        wreg;
        logic        m2reg;
        logic        wmem;
    } idex_t;

    idex_t ex_q;
    idex_t ex_d;

    logic [31:0] fa;
    logic [31:0] fb;
    logic        hazard_raw;

    // The instruction in EX writes a register that the instruction in ID reads.
    // Register 0 is hard-wired, so it never creates a dependency.
    logic e_hit;
    assign e_hit = (ex_q.rn != 5'd0) && ((ex_q.rn == d_rs) || (ex_q.rn == d_rt));

`ifdef IDEX_FWD_EN
    // Forwarding source for one EX operand; EX/MEM is younger than MEM/WB so it wins.
    function automatic logic [31:0] fwd_sel(input logic [4:0] idx, input logic [31:0] rf_val);
        if (m_wreg && (m_rn != 5'd0) && (m_rn == idx))
            return m_alu;
        else if (w_wreg && (w_rn != 5'd0) && (w_rn == idx))
            return w_data;
        else
            return rf_val;
    endfunction

    assign fa = fwd_sel(ex_q.rs, ex_q.qa);
    assign fb = fwd_sel(ex_q.rt, ex_q.qb);

    // Only a load in EX cannot be covered by forwarding: its data exists one stage later.
    assign hazard_raw = ex_q.valid && ex_q.m2reg && e_hit;
`else
    // Without forwarding the consumer waits until the producer has reached WB; the
    // register file writes in the first half-cycle, so a WB producer is already visible.
    logic m_hit;
    assign m_hit = m_wreg && (m_rn != 5'd0) && ((m_rn == d_rs) || (m_rn == d_rt));

    assign fa = ex_q.qa;
    assign fb = ex_q.qb;

    assign hazard_raw = (ex_q.valid && ex_q.wreg && e_hit) || m_hit;

    // Writeback data paths only matter when forwarding is built in.
    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{m_alu, w_wreg, w_rn, w_data};
`endif

    // A squashed instruction cannot depend on anything, so flush masks the hazard.
    assign load_hazard = d_valid && !flush && hazard_raw;

    // Next-state: hold beats bubble beats load. Stall with flush holds; the flush
    // owner re-asserts once the stall drops.
    always_comb begin
        ex_d = ex_q;
        if (!stall) begin
            if (flush || load_hazard) begin
                ex_d = '0;
            end else begin
                ex_d.valid  = d_valid;
                ex_d.qa     = d_qa;
                ex_d.qb     = d_qb;
                ex_d.imm    = d_imm;
                ex_d.sa     = d_sa;
                ex_d.rs     = d_rs;
                ex_d.rt     = d_rt;
                ex_d.rn     = d_rn;
                ex_d.aluc   = d_aluc;
                ex_d.aluimm = d_aluimm;
                ex_d.shift  = d_shift;
                ex_d.wreg   = d_wreg;
                ex_d.m2reg  = d_m2reg;
                ex_d.wmem   = d_wmem;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            ex_q <= '0;
        else
            ex_q <= ex_d;
    end

    // Shifts take the amount from the instruction field, zero-extended.
    assign alu_a   = ex_q.shift  ? {27'b0, ex_q.sa} : fa;
    assign alu_b   = ex_q.aluimm ? ex_q.imm : fb;
    // Stores always need the (forwarded) rt value, even though alu_b carries the offset.
    assign e_store = fb;
    assign aluc    = ex_q.aluc;
    assign e_valid = ex_q.valid;
    assign e_wreg  = ex_q.wreg;
    assign e_m2reg = ex_q.m2reg;
    assign e_wmem  = ex_q.wmem;
    assign e_rn    = ex_q.rn;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush, d_valid;
    logic [31:0] d_qa, d_qb, d_imm;
    logic [4:0]  d_sa, d_rs, d_rt, d_rn;
    logic [3:0]  d_aluc;
    logic        d_aluimm, d_shift, d_wreg, d_m2reg, d_wmem;
    logic        m_wreg, w_wreg;
    logic [4:0]  m_rn, w_rn;
    logic [31:0] m_alu, w_data;
    logic        load_hazard;
    logic [31:0] alu_a, alu_b, e_store;
    logic [3:0]  aluc;
    logic        e_valid, e_wreg, e_m2reg, e_wmem;
    logic [4:0]  e_rn;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .d_valid(d_valid),
        .d_qa(d_qa), .d_qb(d_qb), .d_imm(d_imm), .d_sa(d_sa),
        .d_rs(d_rs), .d_rt(d_rt), .d_rn(d_rn), .d_aluc(d_aluc),
        .d_aluimm(d_aluimm), .d_shift(d_shift), .d_wreg(d_wreg),
        .d_m2reg(d_m2reg), .d_wmem(d_wmem),
        .m_wreg(m_wreg), .m_rn(m_rn), .m_alu(m_alu),
        .w_wreg(w_wreg), .w_rn(w_rn), .w_data(w_data),
        .load_hazard(load_hazard), .alu_a(alu_a), .alu_b(alu_b), .aluc(aluc),
        .e_valid(e_valid), .e_wreg(e_wreg), .e_m2reg(e_m2reg), .e_wmem(e_wmem),
        .e_rn(e_rn), .e_store(e_store)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        hz;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  al;
        logic        v;
        logic        wr;
        logic        m2;
        logic        wm;
        logic [4:0]  rn;
        logic [31:0] st;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_pass = 0;
    int    n_total = 0;

    // Monitor: every cycle that has an expectation queued, compare the live outputs.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            exp_t  g;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            g  = {load_hazard, alu_a, alu_b, aluc, e_valid, e_wreg, e_m2reg, e_wmem, e_rn, e_store};
            n_total++;
            if (g === e)
                n_pass++;
            else
                $display("FAIL %s: got hz=%0b a=%h b=%h aluc=%h v=%0b wreg=%0b m2reg=%0b wmem=%0b rn=%0d st=%h, expected hz=%0b a=%h b=%h aluc=%h v=%0b wreg=%0b m2reg=%0b wmem=%0b rn=%0d st=%h",
                         nm, g.hz, g.a, g.b, g.al, g.v, g.wr, g.m2, g.wm, g.rn, g.st,
                         e.hz, e.a, e.b, e.al, e.v, e.wr, e.m2, e.wm, e.rn, e.st);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic v, input logic [31:0] qa, qb, imm, input logic [4:0] sa, rs, rt, rn,
                         input logic [3:0] al, input logic aimm, sh, wr, m2, wm);
        d_valid = v;  d_qa = qa;  d_qb = qb;  d_imm = imm;  d_sa = sa;
        d_rs = rs;  d_rt = rt;  d_rn = rn;  d_aluc = al;
        d_aluimm = aimm;  d_shift = sh;  d_wreg = wr;  d_m2reg = m2;  d_wmem = wm;
    endtask

    task automatic idle();
        set_d(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic set_mw(input logic mw, input logic [4:0] mrn, input logic [31:0] malu,
                          input logic ww, input logic [4:0] wrn, input logic [31:0] wdat);
        m_wreg = mw;  m_rn = mrn;  m_alu = malu;
        w_wreg = ww;  w_rn = wrn;  w_data = wdat;
    endtask

    // Queue the outputs expected during the current cycle, then advance one edge.
    task automatic chk(input string nm, input logic hz, input logic [31:0] a, b, input logic [3:0] al,
                       input logic v, wr, m2, wm, input logic [4:0] rn, input logic [31:0] st);
        exp_t e;
        e = {hz, a, b, al, v, wr, m2, wm, rn, st};
        exp_q.push_back(e);
        name_q.push_back(nm);
        tick();
    endtask

    task automatic chk_zero(input string nm, input logic hz);
        chk(nm, hz, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1;  stall = 0;  flush = 0;
        set_mw(0, 0, 0, 0, 0, 0);
        set_d(1, 32'h10, 32'h02, 0, 0, 1, 2, 3, 4'h1, 0, 0, 1, 0, 0);
        tick();
        chk_zero("reset", 0);
        rst = 0;

`ifdef IDEX_FWD_EN
        // ADD r3=r1+r2 ; ADD r4=r3+r3 with M beating W
        set_d(1, 32'h10, 32'h02, 0, 0, 1, 2, 3, 4'h1, 0, 0, 1, 0, 0);
        chk_zero("add1_issue", 0);
        set_d(1, 0, 0, 0, 0, 3, 3, 4, 4'h1, 0, 0, 1, 0, 0);
        chk("add1_ex", 0, 32'h10, 32'h02, 4'h1, 1, 1, 0, 0, 3, 32'h02);
        idle();  set_mw(1, 3, 32'h12, 1, 3, 32'h5);
        chk("add2_fwd_m_over_w", 0, 32'h12, 32'h12, 4'h1, 1, 1, 0, 0, 4, 32'h12);
        // LW r5 ; ADD r6=r5+r0
        set_mw(0, 0, 0, 0, 0, 0);
        set_d(1, 32'h100, 32'h77, 32'h4, 0, 1, 5, 5, 4'h1, 1, 0, 1, 1, 0);
        chk_zero("lw_issue", 0);
        set_d(1, 0, 0, 0, 0, 5, 0, 6, 4'h1, 0, 0, 1, 0, 0);
        chk("lw_use_hazard", 1, 32'h100, 32'h4, 4'h1, 1, 1, 1, 0, 5, 32'h77);
        set_mw(1, 5, 32'h104, 0, 0, 0);
        chk_zero("lw_bubble", 0);
        idle();  set_mw(0, 0, 0, 1, 5, 32'hCAFE);
        chk("lw_use_fwd_w", 0, 32'hCAFE, 0, 4'h1, 1, 1, 0, 0, 6, 0);
        // SLL r7=r2<<7 ; SW r7,-4(r1)
        set_mw(0, 0, 0, 0, 0, 0);
        set_d(1, 0, 32'h3, 0, 7, 0, 2, 7, 4'h3, 0, 1, 1, 0, 0);
        chk_zero("sll_issue", 0);
        set_d(1, 32'h200, 0, 32'hFFFFFFFC, 0, 1, 7, 0, 4'h1, 1, 0, 0, 0, 1);
        set_mw(1, 2, 32'h9, 0, 0, 0);
        chk("sll_shift_fwd_rt", 0, 32'h7, 32'h9, 4'h3, 1, 1, 0, 0, 7, 32'h9);
        idle();  set_mw(1, 7, 32'h480, 0, 0, 0);
        chk("sw_imm_store_fwd", 0, 32'h200, 32'hFFFFFFFC, 4'h1, 1, 0, 0, 1, 0, 32'h480);
        // Stall while a load-use hazard is pending
        set_mw(0, 0, 0, 0, 0, 0);
        set_d(1, 32'h100, 32'h77, 32'h4, 0, 1, 5, 5, 4'h1, 1, 0, 1, 1, 0);
        chk_zero("lw2_issue", 0);
        set_d(1, 0, 0, 0, 0, 5, 0, 6, 4'h1, 0, 0, 1, 0, 0);
        stall = 1;
        chk("hazard_stall_c1", 1, 32'h100, 32'h4, 4'h1, 1, 1, 1, 0, 5, 32'h77);
        chk("hazard_stall_c2", 1, 32'h100, 32'h4, 4'h1, 1, 1, 1, 0, 5, 32'h77);
        stall = 0;
        chk("hazard_after_stall", 1, 32'h100, 32'h4, 4'h1, 1, 1, 1, 0, 5, 32'h77);
        chk_zero("hazard_bubble", 0);
        // Flush suppresses the hazard
        set_d(1, 32'h100, 32'h77, 32'h4, 0, 1, 5, 5, 4'h1, 1, 0, 1, 1, 0);
        chk("add6_ex", 0, 0, 0, 4'h1, 1, 1, 0, 0, 6, 0);
        set_d(1, 0, 0, 0, 0, 5, 0, 6, 4'h1, 0, 0, 1, 0, 0);
        flush = 1;
        chk("flush_masks_hazard", 0, 32'h100, 32'h4, 4'h1, 1, 1, 1, 0, 5, 32'h77);
        flush = 0;  idle();
        chk_zero("flush_masks_bubble", 0);
`else
        // ADD r3=r1+r2 ; ADD r4=r3+r3 must wait for r3 to reach WB
        set_d(1, 32'h10, 32'h02, 0, 0, 1, 2, 3, 4'h1, 0, 0, 1, 0, 0);
        chk_zero("add1_issue", 0);
        set_d(1, 0, 0, 0, 0, 3, 3, 4, 4'h1, 0, 0, 1, 0, 0);
        stall = 1;
        chk("raw_ex_stalled", 1, 32'h10, 32'h02, 4'h1, 1, 1, 0, 0, 3, 32'h02);
        stall = 0;
        chk("raw_ex_hazard", 1, 32'h10, 32'h02, 4'h1, 1, 1, 0, 0, 3, 32'h02);
        set_mw(1, 3, 32'h12, 0, 0, 0);
        chk_zero("raw_m_hazard", 1);
        set_d(1, 32'h12, 32'h12, 0, 0, 3, 3, 4, 4'h1, 0, 0, 1, 0, 0);
        set_mw(0, 0, 0, 1, 3, 32'h12);
        chk_zero("raw_w_no_hazard", 0);
        idle();  set_mw(1, 3, 32'hEE, 1, 3, 32'h5);
        chk("add2_no_fwd", 0, 32'h12, 32'h12, 4'h1, 1, 1, 0, 0, 4, 32'h12);
        // SLL then SW, operands straight from the register file
        set_mw(0, 0, 0, 0, 0, 0);
        set_d(1, 0, 32'h3, 0, 7, 0, 2, 7, 4'h3, 0, 1, 1, 0, 0);
        chk_zero("sll_issue", 0);
        idle();  set_mw(1, 2, 32'h9, 0, 0, 0);
        chk("sll_shift_no_fwd", 0, 32'h7, 32'h3, 4'h3, 1, 1, 0, 0, 7, 32'h3);
        set_mw(0, 0, 0, 0, 0, 0);
        set_d(1, 32'h200, 32'h55, 32'hFFFFFFFC, 0, 1, 2, 0, 4'h1, 1, 0, 0, 0, 1);
        chk_zero("sw_issue", 0);
        idle();
        chk("sw_imm_store", 0, 32'h200, 32'hFFFFFFFC, 4'h1, 1, 0, 0, 1, 0, 32'h55);
        // Flush suppresses the hazard
        set_d(1, 32'h1, 32'h2, 0, 0, 1, 2, 3, 4'h1, 0, 0, 1, 0, 0);
        chk_zero("x1_issue", 0);
        set_d(1, 0, 0, 0, 0, 3, 0, 5, 4'h1, 0, 0, 1, 0, 0);
        flush = 1;
        chk("flush_masks_hazard", 0, 32'h1, 32'h2, 4'h1, 1, 1, 0, 0, 3, 32'h2);
        flush = 0;  idle();
        chk_zero("flush_masks_bubble", 0);
`endif

        // Stall holds for three cycles, stall+flush holds, then a plain flush bubbles
        set_d(1, 32'h11, 32'h22, 0, 0, 1, 2, 8, 4'h1, 0, 0, 1, 0, 0);
        chk_zero("stall_pre", 0);
        stall = 1;
        set_d(1, 32'h33, 32'h34, 0, 0, 3, 4, 9, 4'h2, 0, 0, 1, 0, 0);
        chk("stall_c1", 0, 32'h11, 32'h22, 4'h1, 1, 1, 0, 0, 8, 32'h22);
        set_d(1, 32'h44, 32'h45, 0, 0, 5, 6, 10, 4'h2, 0, 0, 1, 0, 0);
        chk("stall_c2", 0, 32'h11, 32'h22, 4'h1, 1, 1, 0, 0, 8, 32'h22);
        flush = 1;
        set_d(1, 32'h46, 32'h47, 0, 0, 7, 9, 10, 4'h2, 0, 0, 1, 0, 0);
        chk("stall_flush_hold", 0, 32'h11, 32'h22, 4'h1, 1, 1, 0, 0, 8, 32'h22);
        stall = 0;  flush = 0;
        set_d(1, 32'h55, 32'h66, 0, 0, 1, 3, 11, 4'h1, 0, 0, 1, 0, 0);
        chk("stall_release", 0, 32'h11, 32'h22, 4'h1, 1, 1, 0, 0, 8, 32'h22);
        flush = 1;
        set_d(1, 32'h77, 32'h78, 0, 0, 2, 4, 12, 4'h1, 0, 0, 1, 0, 0);
        chk("flush_pre", 0, 32'h55, 32'h66, 4'h1, 1, 1, 0, 0, 11, 32'h66);
        flush = 0;  idle();
        chk_zero("flush_bubble", 0);

        // Register 0: neither forwarded nor a hazard source
        set_d(1, 32'h10, 32'h3, 0, 0, 0, 0, 0, 4'h1, 1, 0, 1, 1, 0);
        set_mw(1, 0, 32'hDEAD, 1, 0, 32'hBEEF);
        chk_zero("r0_pre", 0);
        set_d(1, 0, 0, 0, 0, 0, 0, 9, 4'h1, 0, 0, 1, 0, 0);
        chk("r0_no_fwd_no_hz", 0, 32'h10, 0, 4'h1, 1, 1, 1, 0, 0, 32'h3);
        // Reset during a stall clears on the same edge
        stall = 1;  rst = 1;  idle();
        chk("rst_in_stall_pre", 0, 0, 0, 4'h1, 1, 1, 0, 0, 9, 0);
        stall = 0;  rst = 0;
        set_mw(0, 0, 0, 0, 0, 0);
        chk_zero("rst_in_stall", 0);

        tick();
        tick();
        n_total++;
        if (exp_q.size() == 0)
            n_pass++;
        else
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register and EX-stage operand selector for the 5-stage MIPS core. Captures decoded operands and control from ID, applies EX/MEM and MEM/WB forwarding, and drives the combinational ALU's `a`, `b`, `aluc` inputs directly. Also detects load-use hazards and inserts bubbles, so ID/IF can stall.

## Interface
- No parameters. Data width fixed at 32, register index 5, `aluc` 4.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `stall` in 1: external hold (e.g. memory wait); register keeps contents.
- `flush` in 1: replace incoming instruction with bubble (branch/jump squash).
- `d_valid` in 1: ID holds a real instruction.
- `d_qa`, `d_qb` in 32: register-file read data for rs, rt.
- `d_imm` in 32: extended immediate (ID does sign/zero extension).
- `d_sa` in 5: shift amount.
- `d_rs`, `d_rt`, `d_rn` in 5: source indices, destination index.
- `d_aluc` in 4: ALU opcode. `d_aluimm`, `d_shift`, `d_wreg`, `d_m2reg`, `d_wmem` in 1 each: control.
- `m_wreg` in 1, `m_rn` in 5, `m_alu` in 32: EX/MEM writeback info.
- `w_wreg` in 1, `w_rn` in 5, `w_data` in 32: MEM/WB writeback info.
- `load_hazard` out 1: combinational; ID/IF must hold this cycle.
- `alu_a`, `alu_b` out 32; `aluc` out 4: ALU operands/opcode.
- `e_valid`, `e_wreg`, `e_m2reg`, `e_wmem` out 1; `e_rn` out 5; `e_store` out 32 (forwarded rt value for SW).

## Operation
- Registered fields: valid, qa, qb, imm, sa, rs, rt, rn, aluc, aluimm, shift, wreg, m2reg, wmem.
- Per rising edge, priority: `rst` → all fields 0; else `stall` → hold; else `flush` or `load_hazard` → bubble (all fields 0); else load `d_*`.
- `load_hazard` = d_valid & e_valid & e_m2reg & e_rn≠0 & (e_rn==d_rs | e_rn==d_rt). Suppressed when `flush` is 1.
- Forwarded rs value fa: if m_wreg & m_rn≠0 & m_rn==e_rs → m_alu; else if w_wreg & w_rn≠0 & w_rn==e_rs → w_data; else qa. fb identical using e_rt/qb. M beats W.
- `alu_a` = e_shift ? {27'b0, sa} : fa.
- `alu_b` = e_aluimm ? imm : fb. `e_store` = fb always.
- `aluc` = registered aluc. Bubble gives 0000 (ADD of 0,0).
- Register 0 never forwarded and never triggers hazard.

## Timing
- One cycle of latency, ID to EX. Outputs are combinational from registers plus M/W forwarding inputs; no extra cycle.
- Reset values: all outputs 0; `load_hazard` 0 (e_valid=0).
- Load-use: exactly one bubble. The next cycle e_m2reg=0 so hazard clears; the dependent value arrives via M/W forwarding.
- `stall` during `load_hazard`: hold wins, hazard stays asserted, bubble enters on the first non-stalled edge.
- `stall` & `flush` together: hold. The flush owner must reassert after the stall.
- `rst` mid-stall: cleared the same edge.

## Configuration
- `IDEX_FWD_EN` defined: forwarding as above.
- Not defined: fa=qa, fb=qb. `load_hazard` widens to any RAW against the EX register (e_wreg, not just m2reg) or against m_wreg/m_rn. The register file writes before it reads, so W needs no check.

## Test plan
- Reset: rst=1 one edge with d_valid=1 → all outputs 0, load_hazard 0.
- ADD r3=r1+r2, then ADD r4=r3+r3 (FWD_EN): m_alu=0x12 in EX2 → alu_a=alu_b=0x12; with m_rn=w_rn=3, w_data=0x5 → M value 0x12 wins.
- LW r5, then ADD r6=r5+r0 → load_hazard=1 one cycle, bubble (e_valid=0, aluc=0), then alu_a=w_data.
- SLL shift=1 sa=7 → alu_a=0x7, alu_b=forwarded rt; SW aluimm=1 imm=0xFFFFFFFC → alu_b=0xFFFFFFFC, e_store=fb.
- stall=1 for 3 cycles with changing d_* → outputs constant; flush with stall=0 → e_valid=0, e_wreg=0.
- Writes to r0 with m_rn=0, m_alu=0xDEAD → no forwarding, no hazard.
